data_ram: RTL and testbench

- Word-organised data memory directly downstream of the CPU memory controller.
- Consumes the controller's RAM-side bus: word address, pre-aligned write data, 4-bit byte select, store/load strobes.
- Returns raw 32-bit words with a valid strobe after a fixed, parameterised read latency.
- Stores are byte-masked. Loads and stores may issue every cycle.

---
 rtl/data_ram.sv | 117 +++++++++++
 tb/tb_data_ram.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// data_ram: word-organised, byte-maskable data memory behind the CPU memory
// controller. Loads return full 32-bit words through a READ_LATENCY-deep
// pipeline; stores are byte-masked. Loads and stores may issue every cycle.
// Optional build macro RAM_OOB_CHECK_EN: addresses above the array are
// rejected (no write, zero read data) and flagged on outOfRange.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module data_ram #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [`DATA_WIDTH-1:0] address,
  input  logic [`DATA_WIDTH-1:0] dataWrite,
  input  logic [3:0]             byteSelect,
  input  logic                   store,
  input  logic                   load,
  output logic [`DATA_WIDTH-1:0] dataRead,
  output logic                   readValid,
  output logic                   outOfRange
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [`DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [AW-1:0]          word_idx;
  logic                   addr_oob;
  logic                   wr_en;
  logic [`DATA_WIDTH-1:0] rd_word;
  logic                   addr_unused;

  logic [READ_LATENCY-1:0] valid_d, valid_q;
  logic [`DATA_WIDTH-1:0]  data_d [READ_LATENCY];
  logic [`DATA_WIDTH-1:0]  data_q [READ_LATENCY];

  // Address decode: word index, range check, gated write enable, raw read word.
  always_comb begin
    word_idx = address[AW+1:2];
`ifdef RAM_OOB_CHECK_EN
    addr_oob = (address >> (AW + 2)) != '0;
`else
    addr_oob = 1'b0;
`endif
    // Strobes seen during reset are dropped, so the array is untouched.
    wr_en    = store & ~reset & ~addr_oob;
    rd_word  = addr_oob ? '0 : mem[word_idx];
  end

  // Byte lanes [1:0] and, in the wrapping build, the high bits are don't-care.
  assign addr_unused = ^address;

  // Byte-masked write port.
  // NOTE: the array has no reset; clearing it would forbid RAM inference and
  // software never relies on initial contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byteSelect[i]) mem[word_idx][8*i +: 8] <= dataWrite[8*i +: 8];
      end
    end
  end

  // Load pipeline next state: stage 0 samples the word at issue (before any
  // same-edge write lands), later stages shift only when data moves in, so
  // the final stage holds the last returned word between returns.
  always_comb begin
    valid_d = '0;
    for (int i = 0; i < READ_LATENCY; i++) data_d[i] = data_q[i];
    valid_d[0] = load;
    if (load) data_d[0] = rd_word;
    for (int i = 1; i < READ_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) data_d[i] = data_q[i-1];
    end
  end

  // Load pipeline registers; reset drops every in-flight return.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign readValid = valid_q[READ_LATENCY-1];
  assign dataRead  = data_q[READ_LATENCY-1];

`ifdef RAM_OOB_CHECK_EN
  logic out_of_range_d, out_of_range_q;

  // One pulse per offending cycle, even with store and load together.
  always_comb begin
    out_of_range_d = (store | load) & addr_oob;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (reset) out_of_range_q <= 1'b0;
    else       out_of_range_q <= out_of_range_d;
  end

  assign outOfRange = out_of_range_q;
`else
  assign outOfRange = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed self-checking bench for data_ram. Two instances share
// all inputs: dut1 (READ_LATENCY=1) and dut3 (READ_LATENCY=3), both 1024 words.

module tb_data_ram;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] dataWrite;
  logic [3:0]  byteSelect;
  logic        store;
  logic        load;

  logic [31:0] dr1, dr3;
  logic        rv1, rv3;
  logic        oob1, oob3;

  int n_cmp;
  int n_bad;

`ifdef RAM_OOB_CHECK_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif

  data_ram #(.DEPTH_WORDS(1024), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .dataWrite(dataWrite),
    .byteSelect(byteSelect), .store(store), .load(load),
    .dataRead(dr1), .readValid(rv1), .outOfRange(oob1)
  );

  data_ram #(.DEPTH_WORDS(1024), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .address(address), .dataWrite(dataWrite),
    .byteSelect(byteSelect), .store(store), .load(load),
    .dataRead(dr3), .readValid(rv3), .outOfRange(oob3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One store cycle; returns 1 time unit after the sampling edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; dataWrite = d; byteSelect = be; store = 1'b1;
    @(posedge clk); #1;
    store = 1'b0; byteSelect = 4'b0000;
  endtask

  // One load cycle; returns 1 time unit after the sampling edge.
  task automatic do_load(input logic [31:0] a);
    address = a; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; store = 1'b1; load = 1'b1;
    address = 32'h40; dataWrite = 32'hFFFF_FFFF; byteSelect = 4'b1111;
    step(2);
    reset = 1'b0; store = 1'b0; load = 1'b0; byteSelect = 4'b0000;
    n_cmp++; if (rv1 !== 1'b0) begin n_bad++; $display("FAIL reset_rv1: got %b expected 0", rv1); end
    n_cmp++; if (dr1 !== 32'h0) begin n_bad++; $display("FAIL reset_dr1: got %h expected 00000000", dr1); end
    n_cmp++; if (rv3 !== 1'b0) begin n_bad++; $display("FAIL reset_rv3: got %b expected 0", rv3); end
    n_cmp++; if (dr3 !== 32'h0) begin n_bad++; $display("FAIL reset_dr3: got %h expected 00000000", dr3); end
    n_cmp++; if (oob1 !== 1'b0) begin n_bad++; $display("FAIL reset_oob: got %b expected 0", oob1); end
    step(3);
    n_cmp++; if (rv3 !== 1'b0) begin n_bad++; $display("FAIL reset_load_ignored: got %b expected 0", rv3); end
  endtask

  task automatic test_round_trip();
    do_store(32'h10, 32'hDEAD_BEEF, 4'b1111);
    n_cmp++; if (rv1 !== 1'b0) begin n_bad++; $display("FAIL rt_idle_rv: got %b expected 0", rv1); end
    do_load(32'h10);
    n_cmp++; if (rv1 !== 1'b1) begin n_bad++; $display("FAIL rt_rv: got %b expected 1", rv1); end
    n_cmp++; if (dr1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rt_data: got %h expected deadbeef", dr1); end
    step(1);
    n_cmp++; if (rv1 !== 1'b0) begin n_bad++; $display("FAIL rt_pulse_width: got %b expected 0", rv1); end
    n_cmp++; if (dr1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rt_hold: got %h expected deadbeef", dr1); end
  endtask

  task automatic test_byte_mask();
    do_store(32'h20, 32'h1122_3344, 4'b1111);
    do_store(32'h20, 32'hAABB_CCDD, 4'b0110);
    do_load(32'h20);
    n_cmp++; if (dr1 !== 32'h11BB_CC44) begin n_bad++; $display("FAIL mask_0110: got %h expected 11bbcc44", dr1); end
    // byteSelect=0 writes nothing; low address bits are ignored.
    do_store(32'h10, 32'h1234_5678, 4'b0000);
    do_load(32'h13);
    n_cmp++; if (dr1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL mask_none: got %h expected deadbeef", dr1); end
    n_cmp++; if (rv1 !== 1'b1) begin n_bad++; $display("FAIL mask_none_rv: got %b expected 1", rv1); end
  endtask

  task automatic test_read_before_write();
    do_store(32'h20, 32'h0000_0005, 4'b1111);
    address = 32'h20; dataWrite = 32'h0000_0009; byteSelect = 4'b1111;
    store = 1'b1; load = 1'b1;
    step(1);
    store = 1'b0; load = 1'b0; byteSelect = 4'b0000;
    n_cmp++; if (dr1 !== 32'h0000_0005) begin n_bad++; $display("FAIL rbw_first: got %h expected 00000005", dr1); end
    do_load(32'h20);
    n_cmp++; if (dr1 !== 32'h0000_0009) begin n_bad++; $display("FAIL rbw_second: got %h expected 00000009", dr1); end
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 4; w++) do_store(32'(w * 4), 32'(32'hA0 + w), 4'b1111);
    step(3);
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) begin
        address = 32'((k - 1) * 4); load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step(1);
      if (k >= 3 && k <= 6) begin
        n_cmp++; if (rv3 !== 1'b1) begin n_bad++; $display("FAIL b2b_rv edge %0d: got %b expected 1", k, rv3); end
        n_cmp++; if (dr3 !== 32'(32'hA0 + k - 3)) begin n_bad++; $display("FAIL b2b_data edge %0d: got %h expected %h", k, dr3, 32'hA0 + k - 3); end
      end else begin
        n_cmp++; if (rv3 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle edge %0d: got %b expected 0", k, rv3); end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_flight();
    do_store(32'h30, 32'hCAFE_0001, 4'b1111);
    step(3);
    do_load(32'h30);
    reset = 1'b1;
    store = 1'b1; load = 1'b1; dataWrite = 32'hFFFF_FFFF; byteSelect = 4'b1111;
    step(1);
    reset = 1'b0; store = 1'b0; load = 1'b0; byteSelect = 4'b0000;
    n_cmp++; if (dr3 !== 32'h0) begin n_bad++; $display("FAIL mid_reset_dr3: got %h expected 00000000", dr3); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (rv3 !== 1'b0) begin n_bad++; $display("FAIL mid_reset_dropped cycle %0d: got %b expected 0", k, rv3); end
      step(1);
    end
    do_load(32'h30);
    step(2);
    n_cmp++; if (rv3 !== 1'b1) begin n_bad++; $display("FAIL mid_reset_reload_rv: got %b expected 1", rv3); end
    n_cmp++; if (dr3 !== 32'hCAFE_0001) begin n_bad++; $display("FAIL mid_reset_mem: got %h expected cafe0001", dr3); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp_w0, exp_hi;
    exp_w0 = OOB_EN ? 32'h0102_0304 : 32'hFFFF_FFFF;
    exp_hi = OOB_EN ? 32'h0000_0000 : 32'hFFFF_FFFF;
    do_store(32'h0, 32'h0102_0304, 4'b1111);
    n_cmp++; if (oob1 !== 1'b0) begin n_bad++; $display("FAIL oob_inrange_store: got %b expected 0", oob1); end
    do_store(32'h1000, 32'hFFFF_FFFF, 4'b1111);
    n_cmp++; if (oob1 !== OOB_EN) begin n_bad++; $display("FAIL oob_store_flag: got %b expected %b", oob1, OOB_EN); end
    do_load(32'h0);
    n_cmp++; if (oob1 !== 1'b0) begin n_bad++; $display("FAIL oob_flag_pulse: got %b expected 0", oob1); end
    n_cmp++; if (dr1 !== exp_w0) begin n_bad++; $display("FAIL oob_word0: got %h expected %h", dr1, exp_w0); end
    do_load(32'h1000);
    n_cmp++; if (oob1 !== OOB_EN) begin n_bad++; $display("FAIL oob_load_flag: got %b expected %b", oob1, OOB_EN); end
    n_cmp++; if (rv1 !== 1'b1) begin n_bad++; $display("FAIL oob_load_rv: got %b expected 1", rv1); end
    n_cmp++; if (dr1 !== exp_hi) begin n_bad++; $display("FAIL oob_load_data: got %h expected %h", dr1, exp_hi); end
    step(1);
    n_cmp++; if (oob1 !== 1'b0) begin n_bad++; $display("FAIL oob_flag_clear: got %b expected 0", oob1); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; store = 1'b0; load = 1'b0;
    address = '0; dataWrite = '0; byteSelect = '0;
    test_reset();
    test_round_trip();
    test_byte_mask();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid_flight();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
